phase_conv_combine: RTL

Streaming stage that sits directly downstream of the image/kernel polyphase splitter. It consumes the four phase sub-images (even/even, even/odd, odd/even, odd/odd) as one 4-pixel beat per cycle, together with the four phase sub-kernels. It recombines them into the stride-2, valid, 3x3 convolution output, one result per accepted beat once the window is primed. Results stream out in raster order with a valid/ready handshake.

---
 rtl/phase_conv_if.sv | 26 ++
 rtl/phase_conv_combine.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/phase_conv_if.sv
// Stream bundle for phase_conv_combine: 4-phase pixel beats in,
// convolution results out; master = upstream/downstream side, slave = block.
interface phase_conv_if #(
  parameter int WIDTH = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH-1:0]   px_ee;
  logic signed [WIDTH-1:0]   px_eo;
  logic signed [WIDTH-1:0]   px_oe;
  logic signed [WIDTH-1:0]   px_oo;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [2*WIDTH+3:0] data_out;
  logic                      out_last;

  modport master (
    output in_valid, px_ee, px_eo, px_oe, px_oo, out_ready,
    input  in_ready, out_valid, data_out, out_last
  );

  modport slave (
    input  in_valid, px_ee, px_eo, px_oe, px_oo, out_ready,
    output in_ready, out_valid, data_out, out_last
  );
endinterface

// File: rtl/phase_conv_combine.sv
// Recombines four polyphase sub-images into a stride-2 valid 3x3 conv.
// Ports: clk, rst (async low), start, k_* sub-kernels, io stream, busy, done.
module phase_conv_combine #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 224,
  parameter int COLS  = 224
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [0:2][0:2][WIDTH-1:0]  k_ee,
  input  logic [0:2][0:2][WIDTH-1:0]  k_eo,
  input  logic [0:2][0:2][WIDTH-1:0]  k_oe,
  input  logic [0:2][0:2][WIDTH-1:0]  k_oo,
  phase_conv_if.slave                 io,
  output logic                        busy,
  output logic                        done
);
  localparam int R  = ROWS / 2;
  localparam int C  = COLS / 2;
  localparam int RW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, nxt;
  logic [RW-1:0] r;
  logic [CW-1:0] c;

  logic signed [WIDTH-1:0] kee00, kee01, kee10, kee11;
  logic signed [WIDTH-1:0] keo00, keo10;
  logic signed [WIDTH-1:0] koe00, koe01;
  logic signed [WIDTH-1:0] koo00;

  logic signed [WIDTH-1:0] lb_ee [C];
  logic signed [WIDTH-1:0] lb_eo [C];
  logic signed [WIDTH-1:0] lb_oe [C];
  logic signed [WIDTH-1:0] lb_oo [C];

  // ul = row r-1, col c-1 ; l = row r, col c-1
  logic signed [WIDTH-1:0] ee_ul, ee_l;
  logic signed [WIDTH-1:0] eo_ul, eo_l;
  logic signed [WIDTH-1:0] oe_ul;
  logic signed [WIDTH-1:0] oo_ul;

  logic signed [PW-1:0] p [9];
  logic signed [SW-1:0] sum;

  logic accept, emit, out_hs;
  logic last_c, last_r;
  logic unused_taps;

  assign unused_taps = ^{k_ee[0][2], k_ee[1][2], k_ee[2],
                         k_eo[0][1], k_eo[0][2],
                         k_eo[1][1], k_eo[1][2], k_eo[2],
                         k_oe[0][2], k_oe[1], k_oe[2],
                         k_oo[0][1], k_oo[0][2],
                         k_oo[1], k_oo[2]};

  assign io.in_ready = (state == S_RUN) &&
                       (!io.out_valid || io.out_ready);
  assign accept = io.in_valid && io.in_ready;
  assign last_c = (c == CW'(C - 1));
  assign last_r = (r == RW'(R - 1));
  assign emit   = accept && (r != '0) && (c != '0);
  assign out_hs = io.out_valid && io.out_ready;
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start) nxt = S_RUN;
      S_RUN:   if (out_hs && io.out_last) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      r     <= '0;
      c     <= '0;
      kee00 <= '0;
      kee01 <= '0;
      kee10 <= '0;
      kee11 <= '0;
      keo00 <= '0;
      keo10 <= '0;
      koe00 <= '0;
      koe01 <= '0;
      koo00 <= '0;
      ee_ul <= '0;
      ee_l  <= '0;
      eo_ul <= '0;
      eo_l  <= '0;
      oe_ul <= '0;
      oo_ul <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start) begin
        r     <= '0;
        c     <= '0;
        kee00 <= k_ee[0][0];
        kee01 <= k_ee[0][1];
        kee10 <= k_ee[1][0];
        kee11 <= k_ee[1][1];
        keo00 <= k_eo[0][0];
        keo10 <= k_eo[1][0];
        koe00 <= k_oe[0][0];
        koe01 <= k_oe[0][1];
        koo00 <= k_oo[0][0];
      end else if (accept) begin
        c <= last_c ? '0 : c + CW'(1);
        if (last_c) r <= last_r ? '0 : r + RW'(1);
        ee_ul <= lb_ee[c];
        ee_l  <= io.px_ee;
        eo_ul <= lb_eo[c];
        eo_l  <= io.px_eo;
        oe_ul <= lb_oe[c];
        oo_ul <= lb_oo[c];
      end
    end
  end

  // Line buffers: slot c holds row r-1 until this beat replaces it.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_ee[c] <= io.px_ee;
      lb_eo[c] <= io.px_eo;
      lb_oe[c] <= io.px_oe;
      lb_oo[c] <= io.px_oo;
    end
  end

  always_comb begin
    p[0] = PW'(kee00) * PW'(ee_ul);
    p[1] = PW'(kee01) * PW'(lb_ee[c]);
    p[2] = PW'(kee10) * PW'(ee_l);
    p[3] = PW'(kee11) * PW'(io.px_ee);
    p[4] = PW'(keo00) * PW'(eo_ul);
    p[5] = PW'(keo10) * PW'(eo_l);
    p[6] = PW'(koe00) * PW'(oe_ul);
    p[7] = PW'(koe01) * PW'(lb_oe[c]);
    p[8] = PW'(koo00) * PW'(oo_ul);
    sum = '0;
    for (int i = 0; i < 9; i++) begin
      sum = sum + SW'(p[i]);
    end
  end

  // emit implies in_ready, so a held result is never overwritten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io.out_valid <= 1'b0;
      io.data_out  <= '0;
      io.out_last  <= 1'b0;
    end else if (emit) begin
      io.out_valid <= 1'b1;
      io.data_out  <= sum;
      io.out_last  <= last_r && last_c;
    end else if (io.out_ready) begin
      io.out_valid <= 1'b0;
      io.out_last  <= 1'b0;
    end
  end
endmodule
